// File: rtl/dds_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dds_pkg                                                                |
// | Shared types for the multi-channel DDS: FSM states, pipeline tag and   |
// | accumulator width helper.                                              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package dds_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } dds_state_t;

   // Tag fields sized for the largest legal configuration (16 channels).
   localparam int c_tag_chan_bits = 4;
   localparam int c_tag_frac_bits = 16;

   typedef struct packed {
      logic [c_tag_chan_bits-1:0] chan;
      logic                       half;
      logic [c_tag_frac_bits-1:0] frac;
   } dds_tag_t;

   function automatic int dds_acc_width(input int lut_size_log2, input int acc_frac_bits);
      return 1 + lut_size_log2 + acc_frac_bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dds_multi_channel_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dds_multi_channel_if                                                   |
// | Control, LUT and sample-output signals of the multi-channel DDS.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface dds_multi_channel_if #(
   parameter int g_num_channels  = 4,
   parameter int g_acc_width     = 43,
   parameter int g_lut_size_log2 = 10,
   parameter int g_lut_word_bits = 36,
   parameter int g_output_bits   = 14,
   parameter int g_ampl_bits     = 16
);
   localparam int c_chan_bits = (g_num_channels > 1) ? $clog2(g_num_channels) : 1;

   logic [c_chan_bits-1:0]     chan_sel_i;
   logic [g_acc_width-1:0]     acc_i;
   logic [g_acc_width-1:0]     tune_i;
   logic                       acc_load_i;
   logic                       tune_load_i;
   logic [g_ampl_bits-1:0]     ampl_i;
   logic                       dreq_i;
   logic [g_lut_size_log2-1:0] lut_addr_o;
   logic [g_lut_word_bits-1:0] lut_data_i;
   logic [g_output_bits-1:0]   y_o;
   logic                       y_valid_o;
   logic [c_chan_bits-1:0]     y_chan_o;
   logic                       busy_o;
   logic                       overrun_o;

   modport master (
      output chan_sel_i, acc_i, tune_i, acc_load_i, tune_load_i, ampl_i, dreq_i, lut_data_i,
      input  lut_addr_o, y_o, y_valid_o, y_chan_o, busy_o, overrun_o
   );

   modport slave (
      input  chan_sel_i, acc_i, tune_i, acc_load_i, tune_load_i, ampl_i, dreq_i, lut_data_i,
      output lut_addr_o, y_o, y_valid_o, y_chan_o, busy_o, overrun_o
   );

endinterface
`default_nettype wire

// File: rtl/dds_interp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dds_interp                                                             |
// | LUT interpolation, half-period negation and optional amplitude scaling |
// | (DDS_AMPL_SCALE_EN). Tag arrives aligned with the LUT address.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module dds_interp
   import dds_pkg::*;
#(
   parameter int g_lut_sample_bits = 18,
   parameter int g_lut_slope_bits  = 18,
   parameter int g_slope_frac_bits = 7,
   parameter int g_interp_bits     = 8,
   parameter int g_output_bits     = 14,
   parameter int g_ampl_bits       = 16
)(
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic                                      tag_valid_i,
   input  dds_tag_t                                  tag_i,
   input  logic [g_lut_slope_bits+g_lut_sample_bits-1:0] lut_data_i,
`ifdef DDS_AMPL_SCALE_EN
   input  logic [g_ampl_bits-1:0]                    ampl_i,
`endif
   output logic [g_output_bits-1:0]                  y_o,
   output logic                                      y_valid_o,
   output logic [c_tag_chan_bits-1:0]                y_chan_o
);
   localparam int c_word_bits = g_lut_slope_bits + g_lut_sample_bits;
   localparam int c_prod_bits = g_lut_slope_bits + c_tag_frac_bits + 1;
   localparam int c_v_bits    = g_lut_sample_bits + 2;
   localparam int c_shift     = g_interp_bits + g_slope_frac_bits;
   localparam int c_out_shift = g_lut_sample_bits - g_output_bits;

   logic                              r_s2_valid;
   dds_tag_t                          r_s2_tag;
   logic                              r_s3_valid;
   logic                              r_s3_half;
   logic [c_tag_chan_bits-1:0]        r_s3_chan;
   logic signed [c_v_bits-1:0]        r_s3_v;

   logic signed [g_lut_slope_bits-1:0]  w_slope;
   logic signed [g_lut_sample_bits-1:0] w_sample;
   logic signed [c_prod_bits-1:0]       w_prod;
   logic signed [c_prod_bits-1:0]       w_corr;
   logic signed [c_v_bits-1:0]          w_v;
   logic signed [c_v_bits-1:0]          w_neg;
   logic signed [c_v_bits-1:0]          w_out_v;
   logic signed [c_v_bits-1:0]          w_out_sh;
   logic                                w_out_valid;
   logic [c_tag_chan_bits-1:0]          w_out_chan;

   assign w_slope  = lut_data_i[c_word_bits-1:g_lut_sample_bits];
   assign w_sample = lut_data_i[g_lut_sample_bits-1:0];
   // frac sits zero-extended in the tag, so the product keeps its weight.
   assign w_prod   = c_prod_bits'(w_slope) * c_prod_bits'($signed({1'b0, r_s2_tag.frac}));
   assign w_corr   = w_prod >>> c_shift;
   assign w_v      = c_v_bits'(w_sample) + c_v_bits'(w_corr);
   assign w_neg    = r_s3_half ? -r_s3_v : r_s3_v;

`ifdef DDS_AMPL_SCALE_EN
   localparam int c_scaled_bits = c_v_bits + g_ampl_bits + 1;

   logic [g_ampl_bits-1:0]            r_s2_ampl;
   logic [g_ampl_bits-1:0]            r_s3_ampl;
   logic                              r_s4_valid;
   logic [c_tag_chan_bits-1:0]        r_s4_chan;
   logic signed [c_v_bits-1:0]        r_s4_v;
   logic signed [c_scaled_bits-1:0]   w_scaled;

   assign w_scaled = (c_scaled_bits'(w_neg) * c_scaled_bits'($signed({1'b0, r_s3_ampl}))) >>> g_ampl_bits;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s2_ampl  <= '0;
         r_s3_ampl  <= '0;
         r_s4_valid <= 1'b0;
         r_s4_chan  <= '0;
         r_s4_v     <= '0;
      end else begin
         r_s2_ampl  <= ampl_i;
         r_s3_ampl  <= r_s2_ampl;
         r_s4_valid <= r_s3_valid;
         r_s4_chan  <= r_s3_chan;
         r_s4_v     <= c_v_bits'(w_scaled);
      end
   end

   assign w_out_v     = r_s4_v;
   assign w_out_valid = r_s4_valid;
   assign w_out_chan  = r_s4_chan;
`else
   assign w_out_v     = w_neg;
   assign w_out_valid = r_s3_valid;
   assign w_out_chan  = r_s3_chan;
`endif

   assign w_out_sh = w_out_v >>> c_out_shift;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s2_valid <= 1'b0;
         r_s2_tag   <= '0;
         r_s3_valid <= 1'b0;
         r_s3_half  <= 1'b0;
         r_s3_chan  <= '0;
         r_s3_v     <= '0;
         y_o        <= '0;
         y_valid_o  <= 1'b0;
         y_chan_o   <= '0;
      end else begin
         r_s2_valid <= tag_valid_i;
         r_s2_tag   <= tag_i;
         r_s3_valid <= r_s2_valid;
         r_s3_half  <= r_s2_tag.half;
         r_s3_chan  <= r_s2_tag.chan;
         r_s3_v     <= w_v;
         y_o        <= g_output_bits'(w_out_sh);
         y_valid_o  <= w_out_valid;
         y_chan_o   <= w_out_chan;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dds_multi_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dds_multi_channel                                                      |
// | Time-multiplexed N-channel DDS sharing one interpolated half-sine LUT. |
// | Optional per-channel amplitude scaling under DDS_AMPL_SCALE_EN.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module dds_multi_channel
   import dds_pkg::*;
#(
   parameter int g_num_channels    = 4,
   parameter int g_lut_size_log2   = 10,
   parameter int g_lut_sample_bits = 18,
   parameter int g_lut_slope_bits  = 18,
   parameter int g_slope_frac_bits = 7,
   parameter int g_acc_frac_bits   = 32,
   parameter int g_interp_bits     = 8,
   parameter int g_output_bits     = 14,
   parameter int g_ampl_bits       = 16
)(
   input  logic               clk_i,
   input  logic               rst_i,
   dds_multi_channel_if.slave bus
);
   localparam int c_acc_bits  = dds_acc_width(g_lut_size_log2, g_acc_frac_bits);
   localparam int c_chan_bits = (g_num_channels > 1) ? $clog2(g_num_channels) : 1;
`ifdef DDS_AMPL_SCALE_EN
   localparam int c_latency = 4;
`else
   localparam int c_latency = 3;
`endif
   localparam logic [c_chan_bits-1:0] c_last_chan  = c_chan_bits'(g_num_channels - 1);
   localparam logic [c_chan_bits-1:0] c_one_chan   = c_chan_bits'(1);
   localparam logic [2:0]             c_drain_last = 3'(c_latency - 1);

   dds_state_t                  r_state;
   logic [c_chan_bits-1:0]      r_cnt;
   logic [2:0]                  r_drain;
   logic                        r_overrun;
   logic [c_acc_bits-1:0]       r_acc  [g_num_channels];
   logic [c_acc_bits-1:0]       r_tune [g_num_channels];
   logic [g_lut_size_log2-1:0]  r_lut_addr;
   dds_tag_t                    r_tag;
   logic                        r_tag_valid;
   logic                        w_accept;
   logic                        w_issue;
   logic [c_chan_bits-1:0]      w_issue_chan;
   logic [c_tag_chan_bits-1:0]  w_y_chan;

   // The accepting edge itself issues channel 0; RUN then walks 1..N-1.
   assign w_accept     = bus.dreq_i && (r_state == IDLE || r_state == DRAIN);
   assign w_issue      = w_accept || (r_state == RUN);
   assign w_issue_chan = w_accept ? '0 : r_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_drain   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= bus.dreq_i && (r_state == RUN);
         if (w_accept) begin
            r_state <= RUN;
            r_cnt   <= c_one_chan;
         end else begin
            case (r_state)
               RUN: begin
                  if (r_cnt == c_last_chan) begin
                     r_state <= DRAIN;
                     r_drain <= '0;
                  end else begin
                     r_cnt <= r_cnt + c_one_chan;
                  end
               end
               DRAIN: begin
                  if (r_drain == c_drain_last) r_state <= IDLE;
                  else                         r_drain <= r_drain + 3'd1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   for (genvar j = 0; j < g_num_channels; j++) begin : g_chan
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_acc[j]  <= '0;
            r_tune[j] <= '0;
         end else begin
            // A same-cycle load overrides the issue increment.
            if (bus.acc_load_i && bus.chan_sel_i == c_chan_bits'(j))
               r_acc[j] <= bus.acc_i;
            else if (w_issue && w_issue_chan == c_chan_bits'(j))
               r_acc[j] <= r_acc[j] + r_tune[j];
            if (bus.tune_load_i && bus.chan_sel_i == c_chan_bits'(j))
               r_tune[j] <= bus.tune_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lut_addr  <= '0;
         r_tag       <= '0;
         r_tag_valid <= 1'b0;
      end else begin
         r_tag_valid <= w_issue;
         if (w_issue) begin
            r_lut_addr <= r_acc[w_issue_chan][c_acc_bits-2 -: g_lut_size_log2];
            r_tag.chan <= c_tag_chan_bits'(w_issue_chan);
            r_tag.half <= r_acc[w_issue_chan][c_acc_bits-1];
            r_tag.frac <= c_tag_frac_bits'(r_acc[w_issue_chan][g_acc_frac_bits-1 -: g_interp_bits]);
         end
      end
   end

`ifdef DDS_AMPL_SCALE_EN
   logic [g_ampl_bits-1:0] r_ampl [g_num_channels];
   logic [g_ampl_bits-1:0] r_tag_ampl;

   for (genvar j = 0; j < g_num_channels; j++) begin : g_ampl
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i)
            r_ampl[j] <= '1;
         else if (bus.tune_load_i && bus.chan_sel_i == c_chan_bits'(j))
            r_ampl[j] <= bus.ampl_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        r_tag_ampl <= '0;
      else if (w_issue) r_tag_ampl <= r_ampl[w_issue_chan];
   end
`endif

   dds_interp #(
      .g_lut_sample_bits (g_lut_sample_bits),
      .g_lut_slope_bits  (g_lut_slope_bits),
      .g_slope_frac_bits (g_slope_frac_bits),
      .g_interp_bits     (g_interp_bits),
      .g_output_bits     (g_output_bits),
      .g_ampl_bits       (g_ampl_bits)
   ) u_interp (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tag_valid_i (r_tag_valid),
      .tag_i       (r_tag),
      .lut_data_i  (bus.lut_data_i),
`ifdef DDS_AMPL_SCALE_EN
      .ampl_i      (r_tag_ampl),
`endif
      .y_o         (bus.y_o),
      .y_valid_o   (bus.y_valid_o),
      .y_chan_o    (w_y_chan)
   );

   assign bus.y_chan_o   = c_chan_bits'(w_y_chan);
   assign bus.lut_addr_o = r_lut_addr;
   assign bus.busy_o     = (r_state != IDLE);
   assign bus.overrun_o  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dds_multi_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_dds_multi_channel                                                   |
// | Directed vector bench for dds_multi_channel with a sine LUT model.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_dds_multi_channel;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dds_multi_channel_if #(
      .g_num_channels(4), .g_acc_width(43), .g_lut_size_log2(10),
      .g_lut_word_bits(36), .g_output_bits(14), .g_ampl_bits(16)
   ) bus ();

   dds_multi_channel dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   logic [35:0] lut [1024];
   always @(posedge clk) bus.lut_data_i <= lut[bus.lut_addr_o];

   typedef struct {
      int          ch;
      logic [42:0] acc;
      longint      exp_y;
      longint      exp_addr;
   } vec_t;

   vec_t               vecs [6];
   int                 n_tests = 0;
   int                 n_fail  = 0;
   logic signed [13:0] got_y    [4];
   logic [9:0]         got_addr [4];
   int                 n_val;
   int                 bad_tag;

   task automatic check(input string name, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic build_lut();
      int   s [1025];
      real  x;
      int   sl;
      for (int i = 0; i < 1024; i++) begin
         x    = 126976.0 * $sin(3.14159265358979 * i / 1024.0);
         s[i] = $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
      end
      s[1024] = 0;
      for (int i = 0; i < 1024; i++) begin
         sl     = (s[i+1] - s[i]) * 128;
         lut[i] = {18'(sl), 18'(s[i])};
      end
   endtask

   task automatic load(input int ch, input logic [42:0] a, input logic [42:0] t);
      @(negedge clk);
      bus.chan_sel_i  = 2'(ch);
      bus.acc_i       = a;
      bus.tune_i      = t;
      bus.acc_load_i  = 1'b1;
      bus.tune_load_i = 1'b1;
      @(negedge clk);
      bus.acc_load_i  = 1'b0;
      bus.tune_load_i = 1'b0;
   endtask

   // One request; c counts cycles after the dreq cycle.
   task automatic do_req();
      n_val   = 0;
      bad_tag = 0;
      @(negedge clk) bus.dreq_i = 1'b1;
      @(negedge clk) bus.dreq_i = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 1) check("busy_run", bus.busy_o, 1);
         if (c <= 4) got_addr[c-1] = bus.lut_addr_o;
         if (bus.y_valid_o) begin
            n_val++;
            if (c >= 4 && c <= 7 && int'(bus.y_chan_o) == c - 4) got_y[c-4] = bus.y_o;
            else bad_tag++;
         end
         if (c < 12) @(negedge clk);
      end
   endtask

   initial begin
      vecs[0] = '{0, 43'h000_0000_0000,     0,   0};
      vecs[1] = '{1, 43'h200_0000_0000,  7936, 512};
      vecs[2] = '{1, 43'h600_0000_0000, -7936, 512};
      vecs[3] = '{3, 43'h000_8000_0000,    12,   0};
      vecs[4] = '{0, 43'h400_8000_0000,   -13,   0};
      vecs[5] = '{2, 43'h300_0000_0000,  5611, 768};

      bus.chan_sel_i  = '0;
      bus.acc_i       = '0;
      bus.tune_i      = '0;
      bus.acc_load_i  = 1'b0;
      bus.tune_load_i = 1'b0;
      bus.ampl_i      = '1;
      bus.dreq_i      = 1'b0;
      build_lut();

      repeat (3) @(negedge clk);
      check("rst_addr",    bus.lut_addr_o, 0);
      check("rst_y",       bus.y_o,        0);
      check("rst_valid",   bus.y_valid_o,  0);
      check("rst_chan",    bus.y_chan_o,   0);
      check("rst_busy",    bus.busy_o,     0);
      check("rst_overrun", bus.overrun_o,  0);
      rst = 1'b0;

      do_req();
      check("zero_nvalid", n_val, 4);
      check("zero_order",  bad_tag, 0);
      for (int k = 0; k < 4; k++) check("zero_y", got_y[k], 0);
      check("busy_idle", bus.busy_o, 0);

      for (int v = 0; v < 6; v++) begin
         load(vecs[v].ch, vecs[v].acc, 43'h0);
         do_req();
         check("vec_nvalid", n_val, 4);
         check("vec_order",  bad_tag, 0);
         check("vec_y",      got_y[vecs[v].ch],    vecs[v].exp_y);
         check("vec_addr",   got_addr[vecs[v].ch], vecs[v].exp_addr);
      end

      // Second request during RUN is dropped.
      n_val = 0;
      @(negedge clk) bus.dreq_i = 1'b1;
      @(negedge clk) bus.dreq_i = 1'b0;
      check("ovr_quiet", bus.overrun_o, 0);
      @(negedge clk) bus.dreq_i = 1'b1;
      @(negedge clk) bus.dreq_i = 1'b0;
      check("ovr_pulse", bus.overrun_o, 1);
      for (int c = 3; c <= 14; c++) begin
         if (c == 4) check("ovr_one_cycle", bus.overrun_o, 0);
         if (bus.y_valid_o) n_val++;
         @(negedge clk);
      end
      check("ovr_nvalid", n_val, 4);

      // Reset in the middle of a sequence.
      load(2, 43'h200_0000_0000, 43'h0);
      @(negedge clk) bus.dreq_i = 1'b1;
      @(negedge clk) bus.dreq_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_addr", bus.lut_addr_o, 512);
      rst = 1'b1;
      #1;
      check("mid_rst_addr",  bus.lut_addr_o, 0);
      check("mid_rst_y",     bus.y_o,        0);
      check("mid_rst_chan",  bus.y_chan_o,   0);
      check("mid_rst_busy",  bus.busy_o,     0);
      check("mid_rst_valid", bus.y_valid_o,  0);
      @(negedge clk) rst = 1'b0;
      n_val = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.y_valid_o) n_val++;
         @(negedge clk);
      end
      check("mid_rst_novalid", n_val, 0);
      do_req();
      check("mid_rst_acc_clr", got_addr[2], 0);

      // Load colliding with the issue of the same channel.
      load(1, 43'h0, 43'h1_0000_0000);
      @(negedge clk) bus.dreq_i = 1'b1;
      @(negedge clk);
      bus.dreq_i     = 1'b0;
      bus.chan_sel_i = 2'd1;
      bus.acc_i      = 43'h5_0000_0000;
      bus.acc_load_i = 1'b1;
      @(negedge clk);
      bus.acc_load_i = 1'b0;
      check("coll_old_addr", bus.lut_addr_o, 0);
      repeat (10) @(negedge clk);
      do_req();
      check("coll_loaded", got_addr[1], 5);
      do_req();
      check("coll_incr", got_addr[1], 6);

      // Phase wrap on channel 2.
      load(2, 43'h7FF_FFFF_FFFF, 43'h1);
      do_req();
      check("wrap_addr0", got_addr[2], 1023);
      check("wrap_y0",    got_y[2],    -1);
      do_req();
      check("wrap_addr1", got_addr[2], 0);
      check("wrap_y1",    got_y[2],    0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
